// File: rtl/run_scorer.sv
// Per-run score generator: counts ticks and obstacle bonuses during a run, then
// issues one submit request and holds off new runs for a cooldown. Optional streak bonus: SCORE_MULT_EN.
module run_scorer #(
  parameter int unsigned OBST_BONUS    = 10,
  parameter int unsigned MAX_SCORE     = 9999,
  parameter logic [3:0]  SUBMIT_CODE   = 4'd5,
  parameter int unsigned COOLDOWN      = 12,
  parameter int unsigned STREAK_WINDOW = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic [1:0]  player_sel,
  input  logic        tick,
  input  logic        obstacle_passed,
  input  logic        collision,
  output logic [13:0] Score,
  output logic [1:0]  playerID,
  output logic [3:0]  score_req,
  output logic        running,
  output logic        busy
);

  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  if (MAX_SCORE > 16383 || STREAK_WINDOW < 1) begin : g_bad_param
    $error("run_scorer: MAX_SCORE must fit in 14 bits and STREAK_WINDOW must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_SUBMIT,
    S_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cooldown;
  logic [14:0]   bonus_amt;
  logic [14:0]   sum;
  logic [13:0]   next_score;

`ifdef SCORE_MULT_EN
  localparam int GW = $clog2(STREAK_WINDOW + 1);

  logic [1:0]    streak;
  logic [GW-1:0] gap;

  assign bonus_amt = 15'(OBST_BONUS) << streak;

  // Streak only evolves on RUN cycles whose events are actually scored.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
      gap    <= '0;
    end else if (state == S_IDLE && game_start) begin
      streak <= '0;
      gap    <= '0;
    end else if (state == S_RUN && !collision) begin
      if (obstacle_passed) begin
        if (streak != 2'd3) streak <= streak + 2'd1;
        gap <= '0;
      end else if (tick) begin
        if (32'(gap) + 32'd1 >= STREAK_WINDOW) begin
          streak <= '0;
          gap    <= GW'(STREAK_WINDOW);
        end else begin
          gap <= gap + 1'b1;
        end
      end
    end
  end
`else
  assign bonus_amt = 15'(OBST_BONUS);
`endif

  // Widened by one bit so the saturation compare sees any carry past 14 bits.
  assign sum        = {1'b0, Score} + 15'(tick) + (obstacle_passed ? bonus_amt : 15'd0);
  assign next_score = (sum > 15'(MAX_SCORE)) ? 14'(MAX_SCORE) : sum[13:0];

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values; score_req gets its default before the case so it
  // is a one-cycle pulse without needing an explicit clear in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cooldown  <= '0;
      Score     <= '0;
      playerID  <= '0;
      score_req <= '0;
      running   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      score_req <= '0;
      unique case (state)
        S_IDLE: begin
          if (game_start) begin
            state    <= S_RUN;
            Score    <= '0;
            playerID <= player_sel;
            running  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (collision) begin
            state   <= S_SETTLE;
            running <= 1'b0;
          end else begin
            Score <= next_score;
          end
        end
        S_SETTLE: begin
          state     <= S_SUBMIT;
          score_req <= SUBMIT_CODE;
        end
        S_SUBMIT: begin
          state    <= S_WAIT;
          cooldown <= CW'(COOLDOWN);
        end
        S_WAIT: begin
          // Leaving on the edge where the counter would reach zero gives
          // exactly COOLDOWN cycles in WAIT.
          if (cooldown <= CW'(1)) begin
            cooldown <= '0;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else begin
            cooldown <= cooldown - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_scorer.sv
// Directed bench for run_scorer (default build, streak bonus disabled).
module tb_run_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_start;
  logic [1:0]  player_sel;
  logic        tick;
  logic        obstacle_passed;
  logic        collision;
  logic [13:0] Score;
  logic [1:0]  playerID;
  logic [3:0]  score_req;
  logic        running;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int req_count  = 0;

  run_scorer dut (
    .clk            (clk),
    .rst            (rst),
    .game_start     (game_start),
    .player_sel     (player_sel),
    .tick           (tick),
    .obstacle_passed(obstacle_passed),
    .collision      (collision),
    .Score          (Score),
    .playerID       (playerID),
    .score_req      (score_req),
    .running        (running),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (score_req !== 4'd0) req_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [1:0] p);
    game_start = 1'b1;
    player_sel = p;
    cyc(1);
    game_start = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  task automatic event_cycle(input logic t, input logic o, input logic c);
    tick = t;
    obstacle_passed = o;
    collision = c;
    cyc(1);
    tick = 1'b0;
    obstacle_passed = 1'b0;
    collision = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (busy === 1'b0) break;
      cyc(1);
    end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    game_start = 1'b0;
    player_sel = 2'd0;
    tick = 1'b0;
    obstacle_passed = 1'b0;
    collision = 1'b0;
    cyc(2);
    check("rst_score", 32'(Score), 32'd0);
    check("rst_player", 32'(playerID), 32'd0);
    check("rst_req", 32'(score_req), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Basic run: 100 ticks, then collision at edge N.
    start(2'd1);
    check("basic_running", 32'(running), 32'd1);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_player", 32'(playerID), 32'd1);
    ticks(100);
    check("basic_score", 32'(Score), 32'd100);
    event_cycle(1'b0, 1'b0, 1'b1);
    check("basic_run_drop", 32'(running), 32'd0);
    check("basic_req_n", 32'(score_req), 32'd0);
    check("basic_final", 32'(Score), 32'd100);
    cyc(1);
    check("basic_req_n1", 32'(score_req), 32'd5);
    cyc(1);
    check("basic_req_n2", 32'(score_req), 32'd0);
    check("basic_busy_wait", 32'(busy), 32'd1);
    cyc(11);
    check("basic_busy_n13", 32'(busy), 32'd1);
    cyc(1);
    check("basic_busy_n14", 32'(busy), 32'd0);

    // Bonus runs.
    start(2'd1);
    ticks(78);
    event_cycle(1'b0, 1'b1, 1'b0);
    check("bonus1_score", 32'(Score), 32'd88);
    event_cycle(1'b0, 1'b0, 1'b1);
    check("bonus1_final", 32'(Score), 32'd88);
    wait_idle();
    start(2'd2);
    ticks(92);
    event_cycle(1'b0, 1'b1, 1'b0);
    event_cycle(1'b0, 1'b0, 1'b1);
    check("bonus2_final", 32'(Score), 32'd102);
    check("bonus2_player", 32'(playerID), 32'd2);
    cyc(2);
    start(2'd3);  // lands at edge N+3, inside WAIT
    check("wait_start_ignored", 32'(running), 32'd0);
    check("wait_start_player", 32'(playerID), 32'd2);
    cyc(10);
    check("wait_busy_n13", 32'(busy), 32'd1);
    cyc(1);
    check("wait_busy_n14", 32'(busy), 32'd0);
    check("wait_no_run", 32'(running), 32'd0);
    check("wait_score_held", 32'(Score), 32'd102);

    // Simultaneous events.
    start(2'd0);
    event_cycle(1'b1, 1'b1, 1'b0);
    check("tick_plus_obst", 32'(Score), 32'd11);
    ticks(39);
    check("sim_score50", 32'(Score), 32'd50);
    event_cycle(1'b1, 1'b1, 1'b1);
    check("sim_collision_wins", 32'(Score), 32'd50);
    check("sim_running", 32'(running), 32'd0);
    wait_idle();
    event_cycle(1'b1, 1'b1, 1'b1);
    check("idle_events_ignored", 32'(Score), 32'd50);
    check("idle_stays_idle", 32'(busy), 32'd0);

    // Saturation.
    start(2'd1);
    ticks(9995);
    check("sat_9995", 32'(Score), 32'd9995);
    event_cycle(1'b0, 1'b1, 1'b0);
    check("sat_obst", 32'(Score), 32'd9999);
    ticks(3);
    check("sat_hold", 32'(Score), 32'd9999);
    event_cycle(1'b0, 1'b0, 1'b1);
    wait_idle();
    check("sat_final", 32'(Score), 32'd9999);

    // Reset mid-run.
    start(2'd3);
    ticks(40);
    check("rr_score40", 32'(Score), 32'd40);
    check("rr_player", 32'(playerID), 32'd3);
    rst = 1'b1;
    cyc(1);
    check("rr_score", 32'(Score), 32'd0);
    check("rr_player0", 32'(playerID), 32'd0);
    check("rr_running", 32'(running), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc(20);
    check("rr_req", 32'(score_req), 32'd0);
    check("submit_pulses", 32'(req_count), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/run_scorer.md
# run_scorer

Per-run score generator sitting directly upstream of the score tracker. It counts points while a run is in progress: one point per game tick, plus a bonus per obstacle cleared. On collision it freezes the final score and issues a single-cycle submit request carrying the score and the active player ID. It then enforces a cooldown so the tracker has time to compare and store the result before the next run can start.

## Interface
- OBST_BONUS, 10, points added per cleared obstacle (before any streak scaling)
- MAX_SCORE, 9999, saturation ceiling for Score (must be ≤ 16383)
- SUBMIT_CODE, 5, 4-bit request code driven on score_req during submission
- COOLDOWN, 12, cycles spent in WAIT after a submission
- STREAK_WINDOW, 16, ticks allowed between obstacles to keep a streak (used only when SCORE_MULT_EN is defined)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- game_start  in  1  start a run (honoured only in IDLE)
- player_sel  in  2  player for the next run, sampled on game_start
- tick  in  1  single-cycle game step pulse
- obstacle_passed  in  1  single-cycle pulse, obstacle cleared
- collision  in  1  single-cycle pulse, run ends
- Score  out  14  current or final run score, registered
- playerID  out  2  player of current or last run, registered
- score_req  out  4  SUBMIT_CODE for one cycle per submission, else 0
- running  out  1  high in RUN
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: Score=0, playerID=0, score_req=0, running=0, busy=0, state=IDLE; all streak and cooldown counters are 0.
- FSM states: IDLE, RUN, SETTLE, SUBMIT, WAIT.
- IDLE → RUN on game_start.
  - At that edge: Score cleared to 0, playerID loaded from player_sel, streak cleared.
- RUN:
  - Each tick adds 1; each obstacle_passed adds the bonus.
  - tick and obstacle_passed in the same cycle: both are added in that one cycle.
  - collision → SETTLE.
- SETTLE → SUBMIT unconditionally. Score and playerID are frozen from the collision edge onward.
- SUBMIT → WAIT unconditionally. Cooldown counter is loaded with COOLDOWN.
- WAIT: the counter decrements each cycle; at 0 the FSM returns to IDLE.
- Score and playerID hold their values in SETTLE, SUBMIT, WAIT and IDLE until the next accepted game_start.
- Arithmetic:
  - The sum is computed at 15 bits: Score + tick + bonus.
  - If the result exceeds MAX_SCORE, Score = MAX_SCORE (saturating; it never wraps).
- Simultaneous events in RUN:
  - collision with tick and/or obstacle_passed: collision wins; that cycle's tick and bonus are discarded.
- Ignored inputs:
  - game_start outside IDLE is ignored, including during WAIT.
  - tick, obstacle_passed and collision outside RUN are ignored.
- Reset at any time, including mid-RUN or in SUBMIT, returns everything to reset values. No score_req is issued for the aborted run.

## Timing
- collision sampled at edge N (in RUN):
  - Score is final from edge N.
  - score_req = SUBMIT_CODE during cycle N+1 → N+2.
  - score_req returns to 0 at edge N+2.
- Score and playerID are therefore stable for at least one full cycle before score_req asserts and throughout it.
- busy falls COOLDOWN cycles after entering WAIT. Earliest next accepted game_start is edge N+3+COOLDOWN.
- A point update is visible on Score one cycle after the tick/obstacle edge (registered output).
- running asserts at the edge after game_start and deasserts at the collision edge.

## Configuration
- SCORE_MULT_EN defined: streak bonus is enabled.
  - A 2-bit streak counter (0..3) sets bonus = OBST_BONUS << streak, saturating at streak 3 (×8).
  - Each obstacle_passed increments the streak after applying the bonus.
  - A tick counter since the last obstacle clears the streak to 0 once it reaches STREAK_WINDOW.
  - The streak also clears on game_start and on reset.
- SCORE_MULT_EN undefined: bonus is always OBST_BONUS, and no streak logic is synthesised.

## Test plan
- Basic run: reset, game_start with player_sel=1, 100 ticks, collision → Score=100, playerID=1, score_req=5 for exactly one cycle two edges after collision, then 0; busy low 12 cycles after WAIT entry.
- Bonus run (macro off): player_sel=1, 78 ticks plus 1 obstacle, collision → Score=88, one submit pulse; player_sel=2 run with 92 ticks plus 1 obstacle → Score=102, playerID=2.
- Simultaneous events: at Score=50, collision and obstacle_passed and tick in the same cycle → final Score=50; tick+obstacle in the same RUN cycle → +11 in one update.
- Saturation: 9995 ticks then 1 obstacle → Score=9999; further ticks keep 9999.
- Reset and ignores: rst asserted mid-RUN at Score=40 → all outputs 0, no score_req; game_start pulsed during WAIT → no new run, FSM reaches IDLE on schedule.
- SCORE_MULT_EN: three obstacles within 16 ticks → increments 10, 20, 40; a fourth after 16 ticks with no obstacle → +10.
